// File: rtl/lfsr_prng.sv
// ---------------------------------------------------------------------------
// lfsr_prng -- Galois LFSR pseudo-random word generator with a valid/ready
// output handshake.
//
// Each advance shifts the LFSR STEP times in one clock. The result goes into
// both the state register and out_data, and out_valid is raised. A word stays
// stable until the consumer accepts it with out_ready. A seed load takes
// priority over an advance: it replaces the state and the active seed, drops
// any pending word and clears the advance counter.
//
// Parameters
//   WIDTH   LFSR state / output width (2..64)
//   POLY_N  Galois tap mask (WIDTH bits)
//   SEED    reset state, must be nonzero
//   STEP    single shifts applied per advance (1..WIDTH)
//   CNT_W   advance counter width
//
// Ports
//   clk          single clock, rising edge
//   rstn         synchronous active-low reset
//   lfsr_enable  request generation of words
//   load_valid   one-cycle seed load strobe
//   load_seed    new seed value
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer accepts the current word
//   out_data     generated word
//   lfsr_bit     state[0]
//   adv_count    advances since the last reset or load (wraps)
//   period_done  one-cycle pulse when the state returns to the active seed
//
// Optional feature macro: LFSR_PRNG_ZERO_GUARD_EN
//   defined   : a zero load_seed loads SEED instead, and an all-zero state is
//               replaced by SEED on the next clock.
//   undefined : a zero load is taken as-is; the LFSR then locks at zero.
// ---------------------------------------------------------------------------
module lfsr_prng #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY_N = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
  parameter int               STEP   = 1,
  parameter int               CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             lfsr_enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lfsr_bit,
  output logic [CNT_W-1:0] adv_count,
  output logic             period_done
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] adv_count_reg;
  logic             period_done_reg;

  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] load_value;
  logic             fire;
  logic             seed_hit;

  // One right-shifting Galois step. The top bit takes the bit shifted out,
  // independent of POLY_N[WIDTH-1].
  function automatic logic [WIDTH-1:0] galois_shift(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      n[i] = s[i+1] ^ (POLY_N[i] & s[0]);
    end
    n[WIDTH-1] = s[0];
    return n;
  endfunction

  // STEP shifts unrolled into one combinational path.
  always_comb begin
    adv_state = state_reg;
    for (int k = 0; k < STEP; k++) begin
      adv_state = galois_shift(adv_state);
    end
  end

`ifdef LFSR_PRNG_ZERO_GUARD_EN
  // A zero seed would lock the LFSR, so substitute the reset seed.
  assign load_value = (load_seed == '0) ? SEED : load_seed;
`else
  assign load_value = load_seed;
`endif

  // Advance only when the output slot is free or being drained this cycle;
  // a load in the same cycle wins.
  assign fire     = lfsr_enable && (!out_valid_reg || out_ready) && !load_valid;
  assign seed_hit = (adv_state == seed_reg);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg       <= SEED;
      seed_reg        <= SEED;
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      adv_count_reg   <= '0;
      period_done_reg <= 1'b0;
    end else begin
      period_done_reg <= 1'b0;
      if (load_valid) begin
        state_reg     <= load_value;
        seed_reg      <= load_value;
        out_valid_reg <= 1'b0;
        adv_count_reg <= '0;
      end else begin
        if (fire) begin
          state_reg       <= adv_state;
          out_data_reg    <= adv_state;
          out_valid_reg   <= 1'b1;
          adv_count_reg   <= adv_count_reg + 1'b1;
          period_done_reg <= seed_hit;
        end else if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
`ifdef LFSR_PRNG_ZERO_GUARD_EN
        // Recover from a stuck-at-zero state; overrides any advance result.
        if (state_reg == '0) begin
          state_reg <= SEED;
        end
`endif
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign lfsr_bit    = state_reg[0];
  assign adv_count   = adv_count_reg;
  assign period_done = period_done_reg;

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning LFSR state and output width in bits (2..64).
REQ-002 SHALL provide parameter POLY_N, default 16'hB400, WIDTH bits, meaning the Galois tap mask.
REQ-003 SHALL provide parameter SEED, default 16'hACE1, WIDTH bits, meaning the reset state; must be nonzero.
REQ-004 SHALL provide parameter STEP, default 1, meaning LFSR shifts per advance (1..WIDTH).
REQ-005 SHALL provide parameter CNT_W, default 32, meaning advance-counter width.
REQ-006 SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-007 SHALL have port rstn, input, 1 bit, a synchronous active-low reset.
REQ-008 SHALL have port lfsr_enable, input, 1 bit, requesting generation of words.
REQ-009 SHALL have port load_valid, input, 1 bit, a one-cycle seed-load strobe.
REQ-010 SHALL have port load_seed, input, WIDTH bits, the new seed value.
REQ-011 SHALL have port out_valid, output, 1 bit, asserted while out_data holds an unconsumed word.
REQ-012 SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-013 SHALL have port out_data, output, WIDTH bits, the generated word.
REQ-014 SHALL have port lfsr_bit, output, 1 bit, equal to state[0].
REQ-015 SHALL have port adv_count, output, CNT_W bits, the number of advances since the last reset or load.
REQ-016 SHALL have port period_done, output, 1 bit, a one-cycle pulse when the state returns to the active seed.

Function
REQ-017 Single shift SHALL be Galois, right-shifting: next[i] = s[i+1] ^ (POLY_N[i] & s[0]) for i < WIDTH-1, and next[WIDTH-1] = s[0].
REQ-018 Advance SHALL apply the single shift STEP times combinationally within one cycle.
REQ-019 Advance SHALL fire when lfsr_enable && (!out_valid || out_ready) && !load_valid.
REQ-020 On advance, state, out_data and seed_check SHALL take the STEP-shifted state, and out_valid SHALL be set to 1; latency from the fire cycle to out_valid is 1 clock.
REQ-021 Handshake: a word transfers when out_valid && out_ready; while out_valid && !out_ready, out_data and state SHALL hold stable.
REQ-022 Transfer without a new advance, i.e. lfsr_enable low, SHALL clear out_valid on the next clock.
REQ-023 Simultaneous transfer and advance SHALL keep out_valid at 1 and present the new word, with no bubble.
REQ-024 Load SHALL have priority over advance: state and the internal seed_r take load_seed, out_valid clears to 0, and adv_count clears to 0.
REQ-025 adv_count SHALL increment by 1 per advance and wrap modulo 2^CNT_W silently.
REQ-026 period_done SHALL pulse in the cycle after an advance whose new state equals seed_r; at all other times it is 0.
REQ-027 Deasserting lfsr_enable SHALL freeze state; a pending out_valid stays until transferred.

Reset
REQ-028 On rstn low at a clk edge: state = SEED, seed_r = SEED, out_data = 0, out_valid = 0, adv_count = 0, period_done = 0, and lfsr_bit = SEED[0].
REQ-029 Reset mid-handshake SHALL drop the pending word; the first post-reset word is the SEED advance.
REQ-030 Reset SHALL override load_valid and lfsr_enable.

Configuration
REQ-031 Macro LFSR_PRNG_ZERO_GUARD_EN defined: a load with load_seed == 0 SHALL load SEED instead, and an all-zero state detected at any clock SHALL be replaced by SEED on the next clock.
REQ-032 Macro LFSR_PRNG_ZERO_GUARD_EN undefined: a zero load SHALL be taken as-is and the LFSR locks at 0, with advances still counted and period_done repeating every advance.

Verification
REQ-033 Bench SHALL cover: WIDTH=16, STEP=1, defaults, enable with ready=1 -> out_data sequence 0xE270, 0x7138, 0x389C, with out_valid high from cycle 1.
REQ-034 Bench SHALL cover: STEP=2 -> first word 0x7138, second word 0x1C4E.
REQ-035 Bench SHALL cover: ready=0 for 5 cycles after the first word -> out_data held at 0xE270 and adv_count=1 throughout; on ready=1 the next word is 0x7138.
REQ-036 Bench SHALL cover: free-run of 65535 advances -> period_done pulses once with out_data=0xACE1 and adv_count=65535.
REQ-037 Bench SHALL cover: load_valid with load_seed=0x0001 alongside an advance request -> out_valid=0 and adv_count=0, then the next word is 0xB400.
REQ-038 Bench SHALL cover: load_seed=0x0000 -> with LFSR_PRNG_ZERO_GUARD_EN the next word is 0xE270; without it out_data stays 0x0000 and period_done pulses every advance.
